// File: rtl/scytale_decryption_if.sv
`default_nettype none
// ============================================================================
// Module   : scytale_decryption_if
// Brief    : Character stream, key and output bundle for scytale_decryption.
// Revision : 1.0
// ============================================================================
interface scytale_decryption_if #(
    parameter int D_WIDTH   = 8,
    parameter int KEY_WIDTH = 8
);
    logic [D_WIDTH-1:0]   data_i;
    logic                 valid_i;
    logic [KEY_WIDTH-1:0] key_N;
    logic [KEY_WIDTH-1:0] key_M;
    logic                 busy;
    logic [D_WIDTH-1:0]   data_o;
    logic                 valid_o;

    modport master (
        output data_i, valid_i, key_N, key_M,
        input  busy, data_o, valid_o
    );

    modport slave (
        input  data_i, valid_i, key_N, key_M,
        output busy, data_o, valid_o
    );
endinterface
`default_nettype wire

// File: rtl/scytale_decryption.sv
`default_nettype none
// ============================================================================
// Module   : scytale_decryption
// Brief    : Buffers ciphertext until a token, then emits it in scytale order.
// Revision : 1.0
// ============================================================================
module scytale_decryption #(
    parameter int                 D_WIDTH                = 8,
    parameter int                 KEY_WIDTH              = 8,
    parameter int                 MAX_NOF_CHARS          = 50,
    parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = 8'hFA
) (
    input  logic                 clk,
    input  logic                 rst,
    scytale_decryption_if.slave  bus
);
    localparam int CNT_W = $clog2(MAX_NOF_CHARS + 1);
    localparam int IDX_W = 2 * KEY_WIDTH + CNT_W;
    localparam logic [CNT_W-1:0]     C_MAX_CNT = CNT_W'(MAX_NOF_CHARS);
    localparam logic [IDX_W-1:0]     C_MAX_IDX = IDX_W'(MAX_NOF_CHARS);
    localparam logic [KEY_WIDTH-1:0] C_ONE     = KEY_WIDTH'(1);

    typedef enum logic [0:0] {
        S_COLLECT = 1'b0,
        S_DECRYPT = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [CNT_W-1:0]     out_cnt_q, out_cnt_d;
    logic [KEY_WIDTH-1:0] n_q, n_d, m_q, m_d;
    logic [KEY_WIDTH-1:0] row_q, row_d;
    logic [CNT_W-1:0]     col_q, col_d;
    logic                 busy_q, busy_d, valid_q, valid_d;
    logic [D_WIDTH-1:0]   data_q, data_d;
    logic [D_WIDTH-1:0]   buf_q [MAX_NOF_CHARS];

    logic                 w_wr_en;
    logic [KEY_WIDTH-1:0] w_n_eff, w_m_eff;
    logic [IDX_W-1:0]     w_idx;
    logic [D_WIDTH-1:0]   w_rd_data;

    assign w_n_eff   = (bus.key_N == '0) ? C_ONE : bus.key_N;
    assign w_m_eff   = (bus.key_M == '0) ? C_ONE : bus.key_M;
    assign w_idx     = IDX_W'(row_q) * IDX_W'(n_q) + IDX_W'(col_q);
    assign w_rd_data = (w_idx < C_MAX_IDX) ? buf_q[w_idx[CNT_W-1:0]] : '0;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        out_cnt_d = out_cnt_q;
        n_d       = n_q;
        m_d       = m_q;
        row_d     = row_q;
        col_d     = col_q;
        busy_d    = 1'b0;
        valid_d   = 1'b0;
        data_d    = '0;
        w_wr_en   = 1'b0;
        case (state_q)
            S_COLLECT: begin
                if (bus.valid_i) begin
                    if (bus.data_i == START_DECRYPTION_TOKEN) begin
                        state_d   = S_DECRYPT;
                        n_d       = w_n_eff;
                        m_d       = w_m_eff;
                        busy_d    = 1'b1;
                        out_cnt_d = '0;
                        row_d     = '0;
                        col_d     = '0;
                        // Output 0 is always buf[0]; emit it now and pre-step to output 1
                        if (count_q != '0) begin
                            valid_d   = 1'b1;
                            data_d    = buf_q[0];
                            out_cnt_d = CNT_W'(1);
                            row_d     = (w_m_eff == C_ONE) ? '0 : C_ONE;
                            col_d     = (w_m_eff == C_ONE) ? CNT_W'(1) : '0;
                        end
                    end else if (count_q < C_MAX_CNT) begin
                        w_wr_en = 1'b1;
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            S_DECRYPT: begin
                if (out_cnt_q < count_q) begin
                    busy_d    = 1'b1;
                    valid_d   = 1'b1;
                    data_d    = w_rd_data;
                    out_cnt_d = out_cnt_q + CNT_W'(1);
                    if (row_q == m_q - C_ONE) begin
                        row_d = '0;
                        col_d = col_q + CNT_W'(1);
                    end else begin
                        row_d = row_q + C_ONE;
                    end
                end else begin
                    state_d   = S_COLLECT;
                    count_d   = '0;
                    out_cnt_d = '0;
                    row_d     = '0;
                    col_d     = '0;
                end
            end
            default: state_d = S_COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_COLLECT;
            count_q   <= '0;
            out_cnt_q <= '0;
            n_q       <= '0;
            m_q       <= '0;
            row_q     <= '0;
            col_q     <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            out_cnt_q <= out_cnt_d;
            n_q       <= n_d;
            m_q       <= m_d;
            row_q     <= row_d;
            col_q     <= col_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
        end
    end

    // Storage needs no reset: reads are bounded by count, which is reset
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            buf_q[count_q] <= bus.data_i;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.valid_o = valid_q;
    assign bus.data_o  = data_q;
endmodule
`default_nettype wire

// File: doc/scytale_decryption.md
SCYTALE_DECRYPTION -- requirements
Module: scytale_decryption

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- D_WIDTH, 8, character width in bits.
- KEY_WIDTH, 8, width of each key field.
- MAX_NOF_CHARS, 50, character buffer depth.
- START_DECRYPTION_TOKEN, 8'hFA, end-of-message / start-decryption marker.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- data_i  in  D_WIDTH  ciphertext character.
- valid_i  in  1  data_i qualifier.
- key_N  in  KEY_WIDTH  column count; driven from the regfile's scytale_key[15:8].
- key_M  in  KEY_WIDTH  row count; driven from the regfile's scytale_key[7:0].
- busy  out  1  decryption in progress; input ignored.
- data_o  out  D_WIDTH  plaintext character.
- valid_o  out  1  data_o qualifier.

Function
REQ-003 The block SHALL have two states: COLLECT (reset state) and DECRYPT.

REQ-004 COLLECT, valid_i=1, data_i!=token, count<MAX_NOF_CHARS: store data_i at buf[count]; count SHALL increment by 1.

REQ-005 COLLECT, valid_i=1, data_i!=token, count==MAX_NOF_CHARS: character SHALL be dropped; count unchanged; no error.

REQ-006 COLLECT, valid_i=1, data_i==token:
- token SHALL NOT be stored;
- key_N and key_M SHALL be latched;
- next state SHALL be DECRYPT.

REQ-007 A latched key value of 0 SHALL be treated as 1.

REQ-008 Timing for a token accepted on edge T with count=L>0:
- busy=1 and valid_o=1 on cycles T+1..T+L;
- busy=0 and valid_o=0 from T+L+1;
- state returns to COLLECT with count=0 at that point.

REQ-009 The k-th output (k=0..L-1) SHALL be buf[(k mod M)*N + (k div M)], using latched N and M. This SHALL be realised with a row counter (0..M-1) and a column counter; no divider.

REQ-010 If N*M != L, exactly L valid_o pulses SHALL still occur. data_o values for indices >= L are unspecified.

REQ-011 Token with L=0: busy=1 for cycle T+1 only; valid_o stays 0; return to COLLECT.

REQ-012 While busy=1:
- valid_i/data_i SHALL be ignored, including tokens;
- key_N/key_M changes SHALL NOT affect the current message.

REQ-013 When valid_o=0, data_o SHALL be 0.

REQ-014 Index arithmetic SHALL be wide enough for 255*255 without wrap. A computed index >= MAX_NOF_CHARS SHALL yield data_o=0.

REQ-015 Outputs SHALL be registered; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-016 rst=1 sampled at an edge SHALL, on the next cycle, give:
- busy=0, valid_o=0, data_o=0;
- count=0, state=COLLECT;
- latched keys cleared.

REQ-017 Reset mid-DECRYPT SHALL abort the message; no further valid_o pulses SHALL follow.

REQ-018 Buffer contents after reset are don't-care.

Verification
REQ-019 The bench SHALL cover these scenarios (stimulus -> required response):
- N=2, M=3; input "ABCDEF" then 0xFA -> busy 6 cycles starting T+1; data_o "ACEBDF", one per cycle.
- 0xFA with no prior characters -> busy high 1 cycle; valid_o never asserted.
- N=5, M=10; 51 characters then 0xFA -> exactly 50 valid_o pulses; 51st character absent.
- During busy, drive valid_i with "XYZ", then token, and change key_N to 7 -> output unchanged; no second message starts.
- rst=1 at the third output cycle of a 6-character message -> next cycle busy=0, valid_o=0, data_o=0; then new "AB", N=1, M=2, token -> outputs "AB".
- Back-to-back messages "ABCD" (N=2, M=2) -> "ACBD"; then "WXYZ" (N=2, M=2) -> "WYXZ"; no gap cycles beyond REQ-008.
